// File: rtl/tnoc_pkg.sv
// -----------------------------------------------------------------------------
// tnoc_pkg
// Shared types and constants for the router-to-router flit link slice.
//   - default flit / vc widths and the {vc, flit} buffer entry built from them
//   - slice state encoding used by each skid buffer direction
//   - width of the optional per-direction transfer counters
// Optional feature macro: TNOC_FLIT_R2R_SLICE_COUNTER_EN (uses
// TNOC_SLICE_COUNT_WIDTH).
// -----------------------------------------------------------------------------
package tnoc_pkg;

   localparam int TNOC_FLIT_WIDTH        = 66;
   localparam int TNOC_CHANNELS          = 2;
   // A single-channel link still carries a 1-bit tag so the port never
   // collapses to zero width.
   localparam int TNOC_VC_WIDTH          = (TNOC_CHANNELS > 1) ? $clog2(TNOC_CHANNELS) : 1;
   localparam int TNOC_SLICE_COUNT_WIDTH = 32;

   typedef logic [TNOC_FLIT_WIDTH-1:0] tnoc_flit_t;
   typedef logic [TNOC_VC_WIDTH-1:0]   tnoc_vc_t;

   // One buffer entry: the vc tag travels alongside its flit, uninterpreted.
   typedef struct packed {
      tnoc_vc_t   vc;
      tnoc_flit_t flit;
   } tnoc_flit_entry_t;

   typedef enum logic [1:0] {
      TNOC_SLICE_EMPTY = 2'd0,
      TNOC_SLICE_ONE   = 2'd1,
      TNOC_SLICE_FULL  = 2'd2
   } tnoc_slice_state_e;

endpackage : tnoc_pkg

// File: rtl/tnoc_flit_skid_buffer.sv
// -----------------------------------------------------------------------------
// tnoc_flit_skid_buffer
// One direction of the link slice: a 2-entry full-throughput skid buffer.
// Every output (o_valid, o_vc, o_flit, o_ready) comes straight from a flop, so
// no combinational path crosses the block in either direction.
//
// Ports
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_valid/o_ready       upstream handshake, i_vc/i_flit upstream payload
//   o_valid/i_ready       downstream handshake, o_vc/o_flit downstream payload
//   o_flit_count          output transfer count (only with
//                         TNOC_FLIT_R2R_SLICE_COUNTER_EN defined)
// -----------------------------------------------------------------------------
module tnoc_flit_skid_buffer
   import tnoc_pkg::*;
#(
   parameter int FLIT_WIDTH = TNOC_FLIT_WIDTH,
   parameter int VC_WIDTH   = TNOC_VC_WIDTH
) (
   input  logic                              i_clk,
   input  logic                              i_rst,
   input  logic                              i_valid,
   output logic                              o_ready,
   input  logic [VC_WIDTH-1:0]               i_vc,
   input  logic [FLIT_WIDTH-1:0]             i_flit,
   output logic                              o_valid,
   input  logic                              i_ready,
   output logic [VC_WIDTH-1:0]               o_vc,
`ifdef TNOC_FLIT_R2R_SLICE_COUNTER_EN
   output logic [TNOC_SLICE_COUNT_WIDTH-1:0] o_flit_count,
`endif
   output logic [FLIT_WIDTH-1:0]             o_flit
);

   typedef struct packed {
      logic [VC_WIDTH-1:0]   vc;
      logic [FLIT_WIDTH-1:0] flit;
   } entry_t;

   tnoc_slice_state_e state_q, state_d;
   logic              valid_q, valid_d;
   logic              ready_q, ready_d;
   entry_t            main_q, main_d;
   entry_t            skid_q, skid_d;
   entry_t            in_entry;
   logic              in_xfer;
   logic              out_xfer;

   assign in_entry = '{vc: i_vc, flit: i_flit};
   assign in_xfer  = i_valid && ready_q;
   assign out_xfer = valid_q && i_ready;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;

      case (state_q)
         TNOC_SLICE_EMPTY: begin
            if (in_xfer) begin
               main_d  = in_entry;
               state_d = TNOC_SLICE_ONE;
            end
         end
         TNOC_SLICE_ONE: begin
            if (in_xfer && !out_xfer) begin
               // Downstream stalled: park the new flit behind the head.
               skid_d  = in_entry;
               state_d = TNOC_SLICE_FULL;
            end else if (!in_xfer && out_xfer) begin
               state_d = TNOC_SLICE_EMPTY;
            end else if (in_xfer && out_xfer) begin
               main_d  = in_entry;
            end
         end
         TNOC_SLICE_FULL: begin
            // o_ready is low here, so only the output side can move.
            if (out_xfer) begin
               main_d  = skid_q;
               state_d = TNOC_SLICE_ONE;
            end
         end
         default: begin
            state_d = TNOC_SLICE_EMPTY;
         end
      endcase

      // Handshake flags are decoded from the next state and registered, so
      // o_ready never depends combinationally on i_ready.
      valid_d = (state_d != TNOC_SLICE_EMPTY);
      ready_d = (state_d != TNOC_SLICE_FULL);
   end

   // NOTE: sequential state is updated with non-blocking assignments so every
   // flop samples the pre-edge values regardless of process ordering.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= TNOC_SLICE_EMPTY;
         valid_q <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         ready_q <= ready_d;
      end
   end

   // NOTE: the payload registers carry no reset; their contents are
   // don't-care while valid_q is low, and the state flops alone discard
   // buffered flits on reset.
   always_ff @(posedge i_clk) begin
      main_q <= main_d;
      skid_q <= skid_d;
   end

   assign o_valid = valid_q;
   assign o_ready = ready_q;
   assign o_vc    = main_q.vc;
   assign o_flit  = main_q.flit;

`ifdef TNOC_FLIT_R2R_SLICE_COUNTER_EN
   logic [TNOC_SLICE_COUNT_WIDTH-1:0] count_q;

   // Free-running count of output transfers; wraps naturally at all-ones.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         count_q <= '0;
      end else if (out_xfer) begin
         count_q <= count_q + TNOC_SLICE_COUNT_WIDTH'(1);
      end
   end

   assign o_flit_count = count_q;
`endif

endmodule : tnoc_flit_skid_buffer

// File: rtl/tnoc_flit_r2r_slice.sv
// -----------------------------------------------------------------------------
// tnoc_flit_r2r_slice
// Registered link stage for a router-to-router flit link. Two independent
// skid buffers, one per channel direction, sharing only clock and reset:
//   p2m : router port toward mesh
//   m2p : mesh toward router port
// Each direction adds one cycle of latency and sustains one flit per cycle.
//
// Ports
//   i_clk, i_rst                         clock, asynchronous active-high reset
//   i_p2m_* / o_p2m_ready                p2m upstream side
//   o_p2m_* / i_p2m_ready                p2m downstream side
//   i_m2p_* / o_m2p_ready                m2p upstream side
//   o_m2p_* / i_m2p_ready                m2p downstream side
//   o_p2m_flit_count, o_m2p_flit_count   per-direction output transfer counts
//                                        (only with
//                                        TNOC_FLIT_R2R_SLICE_COUNTER_EN)
// -----------------------------------------------------------------------------
module tnoc_flit_r2r_slice
   import tnoc_pkg::*;
#(
   parameter int FLIT_WIDTH = TNOC_FLIT_WIDTH,
   parameter int CHANNELS   = TNOC_CHANNELS,
   parameter int VC_WIDTH   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                              i_clk,
   input  logic                              i_rst,
   // p2m direction
   input  logic                              i_p2m_valid,
   output logic                              o_p2m_ready,
   input  logic [VC_WIDTH-1:0]               i_p2m_vc,
   input  logic [FLIT_WIDTH-1:0]             i_p2m_flit,
   output logic                              o_p2m_valid,
   input  logic                              i_p2m_ready,
   output logic [VC_WIDTH-1:0]               o_p2m_vc,
   output logic [FLIT_WIDTH-1:0]             o_p2m_flit,
   // m2p direction
   input  logic                              i_m2p_valid,
   output logic                              o_m2p_ready,
   input  logic [VC_WIDTH-1:0]               i_m2p_vc,
   input  logic [FLIT_WIDTH-1:0]             i_m2p_flit,
   output logic                              o_m2p_valid,
   input  logic                              i_m2p_ready,
   output logic [VC_WIDTH-1:0]               o_m2p_vc,
`ifdef TNOC_FLIT_R2R_SLICE_COUNTER_EN
   output logic [TNOC_SLICE_COUNT_WIDTH-1:0] o_p2m_flit_count,
   output logic [TNOC_SLICE_COUNT_WIDTH-1:0] o_m2p_flit_count,
`endif
   output logic [FLIT_WIDTH-1:0]             o_m2p_flit
);

   tnoc_flit_skid_buffer #(
      .FLIT_WIDTH (FLIT_WIDTH),
      .VC_WIDTH   (VC_WIDTH)
   ) u_p2m (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_valid      (i_p2m_valid),
      .o_ready      (o_p2m_ready),
      .i_vc         (i_p2m_vc),
      .i_flit       (i_p2m_flit),
      .o_valid      (o_p2m_valid),
      .i_ready      (i_p2m_ready),
      .o_vc         (o_p2m_vc),
`ifdef TNOC_FLIT_R2R_SLICE_COUNTER_EN
      .o_flit_count (o_p2m_flit_count),
`endif
      .o_flit       (o_p2m_flit)
   );

   tnoc_flit_skid_buffer #(
      .FLIT_WIDTH (FLIT_WIDTH),
      .VC_WIDTH   (VC_WIDTH)
   ) u_m2p (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_valid      (i_m2p_valid),
      .o_ready      (o_m2p_ready),
      .i_vc         (i_m2p_vc),
      .i_flit       (i_m2p_flit),
      .o_valid      (o_m2p_valid),
      .i_ready      (i_m2p_ready),
      .o_vc         (o_m2p_vc),
`ifdef TNOC_FLIT_R2R_SLICE_COUNTER_EN
      .o_flit_count (o_m2p_flit_count),
`endif
      .o_flit       (o_m2p_flit)
   );

endmodule : tnoc_flit_r2r_slice

// File: tb/tb_tnoc_flit_r2r_slice.sv
// -----------------------------------------------------------------------------
// tb_tnoc_flit_r2r_slice
// Self-checking bench for tnoc_flit_r2r_slice. The reference model treats each
// direction as a FIFO of capacity two: valid = not empty, ready = not full,
// output payload = queue head. Inputs change 1 time unit after the rising
// edge; the model and all DUT sampling run on the falling edge.
// Counter checks are compiled only with TNOC_FLIT_R2R_SLICE_COUNTER_EN.
// -----------------------------------------------------------------------------
module tb_tnoc_flit_r2r_slice;
   import tnoc_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       p_iv, p_or, p_ivc, p_ov, p_ir, p_ovc;
   logic [65:0] p_if, p_of;
   logic       m_iv, m_or, m_ivc, m_ov, m_ir, m_ovc;
   logic [65:0] m_if, m_of;
`ifdef TNOC_FLIT_R2R_SLICE_COUNTER_EN
   logic [31:0] p_cnt, m_cnt;
   logic [31:0] p_cnt_m = '0;
   logic [31:0] m_cnt_m = '0;
`endif

   tnoc_flit_r2r_slice dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_p2m_valid (p_iv),
      .o_p2m_ready (p_or),
      .i_p2m_vc    (p_ivc),
      .i_p2m_flit  (p_if),
      .o_p2m_valid (p_ov),
      .i_p2m_ready (p_ir),
      .o_p2m_vc    (p_ovc),
      .o_p2m_flit  (p_of),
      .i_m2p_valid (m_iv),
      .o_m2p_ready (m_or),
      .i_m2p_vc    (m_ivc),
      .i_m2p_flit  (m_if),
      .o_m2p_valid (m_ov),
      .i_m2p_ready (m_ir),
      .o_m2p_vc    (m_ovc),
`ifdef TNOC_FLIT_R2R_SLICE_COUNTER_EN
      .o_p2m_flit_count (p_cnt),
      .o_m2p_flit_count (m_cnt),
`endif
      .o_m2p_flit  (m_of)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model state and logs
   tnoc_flit_entry_t p_q[$], m_q[$];
   tnoc_flit_entry_t p_log[$], m_log[$];
   int               p_log_cyc[$], m_log_cyc[$], p_in_cyc[$], m_in_cyc[$];
   bit               p_rdy_low_seen, m_rdy_high_seen;
   int               cyc = 0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      bit full_p, full_m;
      if (rst) begin
         p_q.delete();
         m_q.delete();
`ifdef TNOC_FLIT_R2R_SLICE_COUNTER_EN
         p_cnt_m = '0;
         m_cnt_m = '0;
`endif
      end else begin
         full_p = (p_q.size() >= 2);
         full_m = (m_q.size() >= 2);
         check("p2m_valid", 96'(p_ov), 96'(p_q.size() != 0));
         check("p2m_ready", 96'(p_or), 96'(!full_p));
         if (p_q.size() != 0) check("p2m_head", 96'({p_ovc, p_of}), 96'(p_q[0]));
         check("m2p_valid", 96'(m_ov), 96'(m_q.size() != 0));
         check("m2p_ready", 96'(m_or), 96'(!full_m));
         if (m_q.size() != 0) check("m2p_head", 96'({m_ovc, m_of}), 96'(m_q[0]));
         if (!p_or) p_rdy_low_seen = 1'b1;
         if (m_or) m_rdy_high_seen = 1'b1;
         if (p_q.size() != 0 && p_ir) begin
            p_log.push_back(p_q.pop_front());
            p_log_cyc.push_back(cyc);
`ifdef TNOC_FLIT_R2R_SLICE_COUNTER_EN
            p_cnt_m++;
`endif
         end
         if (p_iv && !full_p) begin
            p_q.push_back('{vc: p_ivc, flit: p_if});
            p_in_cyc.push_back(cyc);
         end
         if (m_q.size() != 0 && m_ir) begin
            m_log.push_back(m_q.pop_front());
            m_log_cyc.push_back(cyc);
`ifdef TNOC_FLIT_R2R_SLICE_COUNTER_EN
            m_cnt_m++;
`endif
         end
         if (m_iv && !full_m) begin
            m_q.push_back('{vc: m_ivc, flit: m_if});
            m_in_cyc.push_back(cyc);
         end
      end
   end

   // Source drivers: pending queues, optional random bubbles / random ready
   tnoc_flit_entry_t p_pend[$], m_pend[$], p_sent[$], m_sent[$];
   int               p_gap = 0, m_gap = 0;
   bit               p_rnd = 0, m_rnd = 0;

   task automatic cycle();
      bit pa, ma;
      @(negedge clk);
      pa = p_iv && p_or && !rst;
      ma = m_iv && m_or && !rst;
      @(posedge clk);
      #1;
      if (pa) void'(p_pend.pop_front());
      if (ma) void'(m_pend.pop_front());
      // A presented but unaccepted flit stays put until it transfers.
      if (!(p_iv && !pa)) begin
         if (p_pend.size() != 0 && $urandom_range(99) >= p_gap) begin
            p_iv = 1'b1;
            {p_ivc, p_if} = p_pend[0];
         end else p_iv = 1'b0;
      end
      if (!(m_iv && !ma)) begin
         if (m_pend.size() != 0 && $urandom_range(99) >= m_gap) begin
            m_iv = 1'b1;
            {m_ivc, m_if} = m_pend[0];
         end else m_iv = 1'b0;
      end
      if (p_rnd) p_ir = 1'($urandom_range(1));
      if (m_rnd) m_ir = 1'($urandom_range(1));
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   task automatic clear_logs();
      p_log.delete(); p_log_cyc.delete(); p_in_cyc.delete();
      m_log.delete(); m_log_cyc.delete(); m_in_cyc.delete();
      p_rdy_low_seen  = 1'b0;
      m_rdy_high_seen = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      tnoc_flit_entry_t e;
      bit               seen;

      rst = 1'b1;
      p_iv = 0; p_ivc = 0; p_if = '0; p_ir = 0;
      m_iv = 0; m_ivc = 0; m_if = '0; m_ir = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_p2m_valid", 96'(p_ov), 96'(0));
      check("rst_p2m_ready", 96'(p_or), 96'(1));
      check("rst_m2p_valid", 96'(m_ov), 96'(0));
      check("rst_m2p_ready", 96'(m_or), 96'(1));
      rst = 1'b0;

      // Single flit
      clear_logs();
      p_ir = 1'b1;
      e = '{vc: 1'b1, flit: 66'h2_DEAD_BEEF_CAFE_F00D};
      p_pend.push_back(e);
      run(5);
      check("single_count", 96'(p_log.size()), 96'(1));
      if (p_log.size() == 1) begin
         check("single_entry", 96'(p_log[0]), 96'(e));
         check("single_latency", 96'(p_log_cyc[0] - p_in_cyc[0]), 96'(1));
      end
      check("single_ready_never_low", 96'(p_rdy_low_seen), 96'(0));

      // 16 back-to-back flits
      clear_logs();
      for (int i = 0; i < 16; i++) p_pend.push_back('{vc: 1'(i % 2), flit: 66'(i)});
      run(20);
      check("stream_count", 96'(p_log.size()), 96'(16));
      if (p_log.size() == 16) begin
         for (int i = 0; i < 16; i++) begin
            check("stream_entry", 96'(p_log[i]), 96'({1'(i % 2), 66'(i)}));
            check("stream_no_gap", 96'(p_log_cyc[i]), 96'(p_log_cyc[0] + i));
         end
      end

      // Backpressure: ready low from the moment flit 0 appears
      clear_logs();
      p_ir = 1'b0;
      for (int i = 0; i < 5; i++) p_pend.push_back('{vc: 1'(i % 2), flit: 66'h100 + 66'(i)});
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         cycle();
         seen = p_ov;
      end
      check("bp_first_valid", 96'(seen), 96'(1));
      run(4);
      check("bp_ready_low", 96'(p_or), 96'(0));
      check("bp_held_head", 96'(p_of), 96'(66'h100));
      check("bp_accepted", 96'(p_in_cyc.size()), 96'(2));
      check("bp_no_output", 96'(p_log.size()), 96'(0));
      p_ir = 1'b1;
      run(12);
      check("bp_drain_count", 96'(p_log.size()), 96'(5));
      if (p_log.size() == 5)
         for (int i = 0; i < 5; i++) check("bp_drain_entry", 96'(p_log[i].flit), 96'(66'h100 + 66'(i)));

      // Independence: m2p held full while p2m streams
      clear_logs();
      m_ir = 1'b0;
      m_pend.push_back('{vc: 1'b0, flit: 66'h3_AAAA});
      m_pend.push_back('{vc: 1'b1, flit: 66'h3_BBBB});
      run(4);
      check("ind_m2p_full", 96'(m_or), 96'(0));
      m_rdy_high_seen = 1'b0;
      for (int i = 0; i < 8; i++) p_pend.push_back('{vc: 1'(i % 2), flit: 66'h200 + 66'(i)});
      run(12);
      check("ind_p2m_count", 96'(p_log.size()), 96'(8));
      if (p_log.size() == 8)
         check("ind_p2m_no_gap", 96'(p_log_cyc[7] - p_log_cyc[0]), 96'(7));
      check("ind_m2p_ready_stayed_low", 96'(m_rdy_high_seen), 96'(0));
      check("ind_m2p_no_output", 96'(m_log.size()), 96'(0));
      check("ind_m2p_head", 96'(m_of), 96'(66'h3_AAAA));
      m_ir = 1'b1;
      run(4);
      check("ind_m2p_drain", 96'(m_log.size()), 96'(2));

      // Asynchronous reset while FULL
      clear_logs();
      p_ir = 1'b0;
      p_pend.push_back('{vc: 1'b0, flit: 66'h11});
      p_pend.push_back('{vc: 1'b1, flit: 66'h22});
      run(4);
      check("ar_full_before", 96'(p_or), 96'(0));
      #2 rst = 1'b1;
      #1;
      check("ar_valid_immediate", 96'(p_ov), 96'(0));
      check("ar_ready_immediate", 96'(p_or), 96'(1));
      p_pend.delete();
      p_iv = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      clear_logs();
      p_ir = 1'b1;
      e = '{vc: 1'b0, flit: 66'h3_0000_1234};
      p_pend.push_back(e);
      run(5);
      check("ar_after_count", 96'(p_log.size()), 96'(1));
      if (p_log.size() == 1) begin
         check("ar_after_entry", 96'(p_log[0]), 96'(e));
         check("ar_after_latency", 96'(p_log_cyc[0] - p_in_cyc[0]), 96'(1));
      end

      // Randomized traffic on both directions
      clear_logs();
      p_sent.delete(); m_sent.delete();
      for (int i = 0; i < 150; i++) begin
         e = '{vc: 1'($urandom_range(1)), flit: {2'($urandom), $urandom, $urandom}};
         p_pend.push_back(e); p_sent.push_back(e);
         e = '{vc: 1'($urandom_range(1)), flit: {2'($urandom), $urandom, $urandom}};
         m_pend.push_back(e); m_sent.push_back(e);
      end
      p_gap = 30; m_gap = 30; p_rnd = 1; m_rnd = 1;
      run(500);
      p_gap = 0; m_gap = 0; p_rnd = 0; m_rnd = 0; p_ir = 1'b1; m_ir = 1'b1;
      run(200);
      check("rnd_p2m_count", 96'(p_log.size()), 96'(150));
      check("rnd_m2p_count", 96'(m_log.size()), 96'(150));
      if (p_log.size() == 150 && m_log.size() == 150) begin
         for (int i = 0; i < 150; i++) begin
            check("rnd_p2m_order", 96'(p_log[i]), 96'(p_sent[i]));
            check("rnd_m2p_order", 96'(m_log[i]), 96'(m_sent[i]));
         end
      end

`ifdef TNOC_FLIT_R2R_SLICE_COUNTER_EN
      // Transfer counters
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check("cnt_reset_p2m", 96'(p_cnt), 96'(0));
      check("cnt_reset_m2p", 96'(m_cnt), 96'(0));
      for (int i = 0; i < 20; i++) p_pend.push_back('{vc: 1'(i % 2), flit: 66'h400 + 66'(i)});
      for (int i = 0; i < 7; i++) m_pend.push_back('{vc: 1'(i % 2), flit: 66'h500 + 66'(i)});
      run(30);
      check("cnt_p2m_20", 96'(p_cnt), 96'(20));
      check("cnt_m2p_7", 96'(m_cnt), 96'(7));
      check("cnt_p2m_model", 96'(p_cnt), 96'(p_cnt_m));
      force dut.u_p2m.count_q = 32'hFFFF_FFFF;
      #1 release dut.u_p2m.count_q;
      p_cnt_m = 32'hFFFF_FFFF;
      p_pend.push_back('{vc: 1'b1, flit: 66'h777});
      run(4);
      check("cnt_wrap", 96'(p_cnt), 96'(0));
      check("cnt_wrap_model", 96'(p_cnt), 96'(p_cnt_m));
      check("cnt_m2p_unaffected", 96'(m_cnt), 96'(7));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_tnoc_flit_r2r_slice

// File: doc/tnoc_flit_r2r_slice.md
Name: tnoc_flit_r2r_slice

Overview:
- Registered link stage inserted on a router-to-router flit link, between a router port and the two flit channels that make up the link.
- Two independent full-throughput 2-entry skid buffers:
  - p2m direction: port toward mesh.
  - m2p direction: mesh toward port.
- Breaks every combinational path (valid, flit, vc forward; ready backward) so long inter-router wires close timing.
- Adds 1 cycle latency per direction; no flit loss, no reordering, no bubbles under continuous traffic.

Parameters:
- FLIT_WIDTH, 66: width of one flit (type/head/tail bits plus payload).
- CHANNELS, 2: number of virtual channels carried on the link.
- VC_WIDTH, $clog2(CHANNELS) (minimum 1): width of the vc tag.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous reset, active-high
- i_p2m_valid  in  1  upstream p2m flit valid
- o_p2m_ready  out  1  p2m accept to upstream
- i_p2m_vc  in  VC_WIDTH  virtual channel of the incoming p2m flit
- i_p2m_flit  in  FLIT_WIDTH  incoming p2m flit
- o_p2m_valid  out  1  downstream p2m valid
- i_p2m_ready  in  1  downstream p2m accept
- o_p2m_vc  out  VC_WIDTH  registered p2m vc
- o_p2m_flit  out  FLIT_WIDTH  registered p2m flit
- i_m2p_valid / o_m2p_ready / i_m2p_vc / i_m2p_flit: same as the p2m inputs, for the m2p direction.
- o_m2p_valid / i_m2p_ready / o_m2p_vc / o_m2p_flit: same as the p2m outputs, for the m2p direction.

Behaviour:
- Handshake: transfer occurs when valid and ready are both high on a rising i_clk edge.
  - Once valid is asserted, flit and vc must stay stable until the transfer. The block honours this on its outputs and relies on upstream honouring it.
- State machine per direction:
  - EMPTY: o_valid=0, o_ready=1. Input transfer loads the main register → ONE.
  - ONE: o_valid=1, o_ready=1.
    - Input transfer with no output transfer → the input goes into the skid register → FULL.
    - Output transfer with no input transfer → EMPTY.
    - Both in the same cycle → the main register reloads → stays ONE.
  - FULL: o_valid=1, o_ready=0.
    - Output transfer → skid moves into main → ONE.
    - An input valid is not accepted while in FULL.
- o_ready is a register output, never combinational from i_ready.
- o_valid, o_vc and o_flit are driven directly from the main register.
- Latency: a flit accepted at edge N is presented at o_* from edge N, i.e. visible in the following cycle.
- Throughput: 1 flit/cycle sustained while downstream ready stays high.
- Backpressure:
  - Downstream ready low for k≥2 cycles during a stream → exactly 2 flits buffered, o_ready low from the cycle after the second buffered flit is accepted.
  - o_ready rises 1 cycle after the first output transfer.
- Ordering: strict FIFO across all vcs. The vc tag passes through unmodified and is not interpreted.
- Reset:
  - i_rst asserted (asynchronous) clears both directions to EMPTY: o_valid=0, o_ready=1.
  - Flit and vc registers are not reset (datapath only) and are don't-care while o_valid=0.
  - Reset mid-stream discards buffered flits; no partial output after deassertion.
- The p2m and m2p directions share nothing but i_clk and i_rst; activity on one never affects the other.

Optional Feature:
- Macro: TNOC_FLIT_R2R_SLICE_COUNTER_EN
- Defined:
  - Adds outputs o_p2m_flit_count and o_m2p_flit_count, 32 bits each.
  - Each counts output transfers (o_valid && i_ready) of its direction.
  - Reset to 0 by i_rst; wraps from 0xFFFFFFFF to 0.
  - Simultaneous transfers on both directions increment both counters in the same cycle.
- Undefined: ports and counter logic are absent; behaviour is otherwise identical.

Decomposition:
- tnoc_pkg holds:
  - the slice state enum (TNOC_SLICE_EMPTY, TNOC_SLICE_ONE, TNOC_SLICE_FULL);
  - a packed struct of {vc, flit} used as the buffer entry, parameterized via FLIT_WIDTH/VC_WIDTH-sized typedefs;
  - the counter width constant TNOC_SLICE_COUNT_WIDTH = 32.
- Sub-module tnoc_flit_skid_buffer implements one direction (state machine, main and skid registers, optional counter). The top instantiates it twice.

Test Plan:
- Reset then single flit: p2m vc=1, flit=0x2_DEADBEEF_CAFEF00D, downstream ready=1 → o_p2m_valid high the next cycle with identical vc and flit, for one cycle only; o_p2m_ready never falls.
- Streaming: 16 back-to-back flits (payload 0..15, alternating vc 0/1), downstream ready=1 → 16 consecutive output cycles, in order, with no gaps.
- Backpressure:
  - Stream 5 flits and drop i_p2m_ready for 4 cycles after the first output → exactly flits 0 and 1 held, o_p2m_ready low.
  - On release, flits 0–4 exit in order with no duplication or loss.
- Simultaneous in/out in ONE plus independence: hold m2p downstream ready=0 with 2 flits buffered while p2m streams 8 flits → p2m unaffected, m2p o_m2p_ready=0 throughout.
- Async reset mid-operation: assert i_rst between edges while FULL → o_valid=0 and o_ready=1 immediately, without waiting for a clock edge; after release, the first new flit passes normally.
- With TNOC_FLIT_R2R_SLICE_COUNTER_EN:
  - Preload scenario: 20 p2m and 7 m2p transfers → counts 20 and 7.
  - Forcing the counter to 0xFFFFFFFF then 1 transfer → count 0.
